// File: rtl/tx_pkg.sv
// Shared types and constants for the nibble-serial result transmitter.
package tx_pkg;

  localparam int unsigned TX_NIBBLES  = 5;
  localparam int unsigned TX_FRAME_W  = 20;
  localparam logic [2:0]  LAST_NIBBLE = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SHIFT
  } tx_state_t;

  // Nibble 0 is the flag nibble in frame[19:16]; nibbles 1..4 walk the data MSB first.
  function automatic logic [3:0] frame_nibble(input logic [TX_FRAME_W-1:0] frame,
                                              input logic [2:0]            idx);
    logic [3:0] nib;
    nib = 4'h0;
    unique case (idx)
      3'd0:    nib = frame[19:16];
      3'd1:    nib = frame[15:12];
      3'd2:    nib = frame[11:8];
      3'd3:    nib = frame[7:4];
      3'd4:    nib = frame[3:0];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Rising-edge detector for the master-driven SPI clock, sampled in the system clock domain.
module spi_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_clk,
  output logic rise
);

  logic spi_clk_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_clk_prev <= 1'b0;
    end else begin
      spi_clk_prev <= spi_clk;
    end
  end

  assign rise = spi_clk & ~spi_clk_prev;

endmodule

// File: rtl/tx_4b.sv
// Nibble-serial result transmitter: latches a 16-bit result plus flags as a 20-bit frame
// and presents it on a 4-bit MISO bus, one nibble per gated SPI clock rise.
module tx_4b
  import tx_pkg::*;
#(
  parameter int unsigned NIBBLES = TX_NIBBLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk,
  input  logic        spi_r,
  input  logic [15:0] res_data,
  input  logic [3:0]  res_flags,
  input  logic        res_valid,
  output logic        res_ready,
  output logic [3:0]  miso,
  output logic        miso_oe,
  output logic        tx_done
);

  localparam logic [2:0] LastIdx = 3'(NIBBLES - 1);

  tx_state_t             state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [TX_FRAME_W-1:0] frame_q, frame_d;
  logic                  tx_done_q, tx_done_d;
  logic                  spi_clk_rise;
  logic                  shift_ev;

  spi_edge_detect u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .spi_clk (spi_clk),
    .rise    (spi_clk_rise)
  );

  assign shift_ev = spi_clk_rise & spi_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      frame_q   <= '0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      tx_done_q <= tx_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    tx_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (res_valid) begin
          frame_d = {res_flags, res_data};
          cnt_d   = 3'd0;
          state_d = LOADED;
        end
      end
      LOADED: begin
        if (cnt_q > LAST_NIBBLE) begin
          state_d = IDLE;
        end else if (shift_ev) begin
          cnt_d   = 3'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q > LAST_NIBBLE) begin
          state_d = IDLE;
        end else if (!spi_r) begin
          // Aborted read keeps the frame; the next read restarts at nibble 0.
          cnt_d   = 3'd0;
          state_d = LOADED;
        end else if (shift_ev) begin
          if (cnt_q == LastIdx) begin
            state_d   = IDLE;
            tx_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    res_ready = 1'b0;
    miso_oe   = 1'b0;
    miso      = 4'h0;
    unique case (state_q)
      IDLE: begin
        res_ready = 1'b1;
      end
      LOADED: begin
        miso_oe = 1'b1;
        miso    = frame_nibble(frame_q, 3'd0);
      end
      SHIFT: begin
        miso_oe = 1'b1;
        miso    = frame_nibble(frame_q, cnt_q);
      end
      default: begin
        res_ready = 1'b0;
      end
    endcase
  end

  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_tx_4b.sv
// Scoreboard bench for tx_4b: expected MISO nibbles are queued at stimulus time and
// popped by a monitor on every gated SPI clock rise while a frame is presented.
module tb_tx_4b;

  logic        clk;
  logic        rst_n;
  logic        spi_clk;
  logic        spi_r;
  logic [15:0] res_data;
  logic [3:0]  res_flags;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  miso;
  logic        miso_oe;
  logic        tx_done;

  int total;
  int bad;
  int done_cnt;
  logic [3:0] exp_q[$];
  logic spi_prev_tb;

  tx_4b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clk   (spi_clk),
    .spi_r     (spi_r),
    .res_data  (res_data),
    .res_flags (res_flags),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the master samples miso on a gated spi_clk rise, before the DUT advances.
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (spi_clk && !spi_prev_tb && spi_r && miso_oe === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL miso_unexpected: got %0h expected none", miso);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (miso !== e) begin
          bad++;
          $display("FAIL miso_nibble: got %0h expected %0h", miso, e);
        end
      end
    end
    spi_prev_tb = spi_clk;
  end

  task automatic push_frame(input logic [3:0] f, input logic [15:0] d);
    exp_q.push_back(f);
    exp_q.push_back(d[15:12]);
    exp_q.push_back(d[11:8]);
    exp_q.push_back(d[7:4]);
    exp_q.push_back(d[3:0]);
  endtask

  // Entered and left at posedge+1.
  task automatic spi_pulse();
    spi_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    spi_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] f, input logic [15:0] d);
    int n;
    n = 0;
    while (res_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("send_ready_timeout", {31'd0, res_ready}, 32'd1);
    res_valid = 1'b1;
    res_flags = f;
    res_data  = d;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  initial begin
    int d0;
    total = 0; bad = 0; done_cnt = 0; spi_prev_tb = 1'b0;
    rst_n = 1'b0; spi_clk = 1'b0; spi_r = 1'b0;
    res_data = '0; res_flags = '0; res_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset and idle behaviour
    check("rst_ready", {31'd0, res_ready}, 32'd1);
    check("rst_miso", {28'd0, miso}, 32'h0);
    check("rst_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    spi_r = 1'b1;
    repeat (3) spi_pulse();
    check("idle_oe", {31'd0, miso_oe}, 32'd0);
    check("idle_miso", {28'd0, miso}, 32'h0);
    check("idle_done", done_cnt, 32'd0);
    spi_r = 1'b0;

    // Basic frame A / 1234
    push_frame(4'hA, 16'h1234);
    send(4'hA, 16'h1234);
    check("load_oe", {31'd0, miso_oe}, 32'd1);
    check("load_miso", {28'd0, miso}, 32'hA);
    check("load_ready", {31'd0, res_ready}, 32'd0);
    spi_r = 1'b1;
    d0 = done_cnt;
    repeat (5) spi_pulse();
    spi_r = 1'b0;
    check("basic_done", done_cnt - d0, 32'd1);
    check("basic_ready", {31'd0, res_ready}, 32'd1);
    check("basic_oe", {31'd0, miso_oe}, 32'd0);

    // Aborted read restarts from nibble 0
    exp_q.push_back(4'hA);
    exp_q.push_back(4'h1);
    push_frame(4'hA, 16'h1234);
    send(4'hA, 16'h1234);
    spi_r = 1'b1;
    d0 = done_cnt;
    repeat (2) spi_pulse();
    spi_r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_miso", {28'd0, miso}, 32'hA);
    check("abort_oe", {31'd0, miso_oe}, 32'd1);
    check("abort_ready", {31'd0, res_ready}, 32'd0);
    check("abort_nodone", done_cnt - d0, 32'd0);
    spi_r = 1'b1;
    repeat (5) spi_pulse();
    spi_r = 1'b0;
    check("abort_done", done_cnt - d0, 32'd1);

    // res_valid held during transmission; reload in the tx_done cycle
    push_frame(4'hA, 16'h1234);
    send(4'hA, 16'h1234);
    res_valid = 1'b1;
    res_flags = 4'h7;
    res_data  = 16'hFFFF;
    spi_r = 1'b1;
    repeat (4) spi_pulse();
    spi_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("hold_done_pulse", {31'd0, tx_done}, 32'd1);
    check("hold_ready_at_done", {31'd0, res_ready}, 32'd1);
    @(negedge clk);
    check("hold_reload_oe", {31'd0, miso_oe}, 32'd1);
    check("hold_reload_miso", {28'd0, miso}, 32'h7);
    check("hold_reload_ready", {31'd0, res_ready}, 32'd0);
    check("hold_done_once", {31'd0, tx_done}, 32'd0);
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    spi_r = 1'b0;
    spi_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push_frame(4'h7, 16'hFFFF);
    spi_r = 1'b1;
    repeat (5) spi_pulse();
    spi_r = 1'b0;

    // Reset mid-frame
    exp_q.push_back(4'hC);
    exp_q.push_back(4'h9);
    exp_q.push_back(4'h8);
    send(4'hC, 16'h9876);
    spi_r = 1'b1;
    d0 = done_cnt;
    repeat (3) spi_pulse();
    rst_n = 1'b0;
    #2;
    check("rst_mid_ready", {31'd0, res_ready}, 32'd1);
    check("rst_mid_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_mid_miso", {28'd0, miso}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) spi_pulse();
    spi_r = 1'b0;
    check("rst_mid_nodone", done_cnt - d0, 32'd0);
    check("rst_mid_oe_after", {31'd0, miso_oe}, 32'd0);

    // Back-to-back frames
    d0 = done_cnt;
    push_frame(4'h0, 16'h0000);
    send(4'h0, 16'h0000);
    spi_r = 1'b1;
    repeat (5) spi_pulse();
    spi_r = 1'b0;
    push_frame(4'h5, 16'hBEEF);
    send(4'h5, 16'hBEEF);
    spi_r = 1'b1;
    repeat (5) spi_pulse();
    spi_r = 1'b0;
    check("b2b_done", done_cnt - d0, 32'd2);

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
